// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter for the GRF write port: merges the non-stallable W-stage write
// with a FIFO-buffered long-latency producer, one registered write per cycle.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAXWAIT = 8
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   p_valid,
    input  logic [4:0]             p_a3,
    input  logic [31:0]            p_wd,
    input  logic [31:0]            p_pc,
    input  logic                   l_valid,
    output logic                   l_ready,
    input  logic [4:0]             l_a3,
    input  logic [31:0]            l_wd,
    input  logic [31:0]            l_pc,
    output logic                   grf_we,
    output logic [4:0]             grf_a3,
    output logic [31:0]            grf_wd,
    output logic [31:0]            grf_pc,
    output logic [31:0]            pend,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   stall_req,
    output logic                   proto_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = $clog2(MAXWAIT + 1);

    logic [4:0]       q_a3 [DEPTH];
    logic [31:0]      q_wd [DEPTH];
    logic [31:0]      q_pc [DEPTH];
    logic [DEPTH-1:0] q_live;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    age_q;
    logic [AW-1:0]    age_nxt;
    logic             p_iss;
    logic             push;
    logic             enq;
    logic             pop;
    logic             head_live;
    logic             full;
    logic             empty;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == CW'(0));
    assign l_ready   = clr_n && !full;
    assign stall_req = (age_q == AW'(MAXWAIT));
    assign fifo_cnt  = cnt_q;

    // Pipeline always wins; otherwise the head drains, squashed heads silently.
    always_comb begin
        p_iss     = p_valid && (p_a3 != 5'd0);
        push      = l_valid && l_ready;
        enq       = push && (l_a3 != 5'd0);
        head_live = q_live[rd_ptr];
        pop       = !p_iss && !empty;
        age_nxt   = age_q;
        if (empty || pop) begin
            age_nxt = AW'(0);
        end else if (head_live && (age_q != AW'(MAXWAIT))) begin
            age_nxt = age_q + AW'(1);
        end
    end

    // Live flags are cleared on pop, so a set flag always means a held entry.
    always_comb begin
        pend = 32'd0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_live[i]) begin
                pend[q_a3[i]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_a3[wr_ptr] <= l_a3;
            q_wd[wr_ptr] <= l_wd;
            q_pc[wr_ptr] <= l_pc;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt_q     <= '0;
            age_q     <= '0;
            q_live    <= '0;
            grf_we    <= 1'b0;
            grf_a3    <= 5'd0;
            grf_wd    <= 32'd0;
            grf_pc    <= 32'd0;
            proto_err <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CW'(enq) - CW'(pop);
            age_q <= age_nxt;
            if (p_iss && stall_req) begin
                proto_err <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Squash older entries first; a same-cycle push is newer and stays live.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (p_iss && (q_a3[i] == p_a3)) begin
                    q_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_live[rd_ptr] <= 1'b0;
            end
            if (enq) begin
                q_live[wr_ptr] <= 1'b1;
            end
            if (p_iss) begin
                grf_we <= 1'b1;
                grf_a3 <= p_a3;
                grf_wd <= p_wd;
                grf_pc <= p_pc;
            end else if (pop && head_live) begin
                grf_we <= 1'b1;
                grf_a3 <= q_a3[rd_ptr];
                grf_wd <= q_wd[rd_ptr];
                grf_pc <= q_pc[rd_ptr];
            end else begin
                grf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios then random traffic, every cycle
// checked against a queue-based model of the arbitration rules.
module tb_grf_wb_arbiter;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAXWAIT = 8;

    logic        clk;
    logic        clr_n;
    logic        p_valid;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic [31:0] p_pc;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_a3;
    logic [31:0] l_wd;
    logic [31:0] l_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [31:0] pend;
    logic [2:0]  fifo_cnt;
    logic        stall_req;
    logic        proto_err;

    grf_wb_arbiter #(.DEPTH(DEPTH), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .clr_n(clr_n),
        .p_valid(p_valid), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
        .l_valid(l_valid), .l_ready(l_ready), .l_a3(l_a3), .l_wd(l_wd), .l_pc(l_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .pend(pend), .fifo_cnt(fifo_cnt), .stall_req(stall_req), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;
    int          m_age;
    bit          m_proto;
    int          cmp;
    int          bad;
    int          cyc;
    bit          acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_a3 = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
        m_age = 0; m_proto = 1'b0;
    endtask

    // One clock: drive at negedge, compare against model, advance model, settle past posedge.
    task automatic step(input bit pv, input logic [4:0] pa3, input logic [31:0] pwd,
                        input bit lv, input logic [4:0] la3, input logic [31:0] lwd);
        logic [31:0] ep;
        bit          p_iss;
        bit          push;
        int          nage;
        ent_t        h;
        @(negedge clk);
        cyc++;
        p_valid = pv; p_a3 = pa3; p_wd = pwd; p_pc = 32'h8000_0000 | 32'(cyc);
        l_valid = lv; l_a3 = la3; l_wd = lwd; l_pc = 32'h4000_0000 | 32'(cyc);
        #1;
        ep = 32'd0;
        foreach (mq[i]) if (mq[i].live) ep[mq[i].a3] = 1'b1;
        chk("l_ready", 64'(l_ready), 64'(mq.size() < DEPTH));
        chk("pend", 64'(pend), 64'(ep));
        chk("fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
        chk("stall_req", 64'(stall_req), 64'(m_age == MAXWAIT));
        chk("proto_err", 64'(proto_err), 64'(m_proto));
        chk("grf_we", 64'(grf_we), 64'(m_we));
        if (m_we) begin
            chk("grf_a3", 64'(grf_a3), 64'(m_a3));
            chk("grf_wd", 64'(grf_wd), 64'(m_wd));
            chk("grf_pc", 64'(grf_pc), 64'(m_pc));
        end
        p_iss = pv && (pa3 != 5'd0);
        push  = lv && (mq.size() < DEPTH);
        acc   = push;
        if (p_iss && (m_age == MAXWAIT)) m_proto = 1'b1;
        if (mq.size() == 0 || !p_iss) nage = 0;
        else if (mq[0].live) nage = (m_age < MAXWAIT) ? m_age + 1 : m_age;
        else nage = m_age;
        m_age = nage;
        if (p_iss) begin
            m_we = 1'b1; m_a3 = pa3; m_wd = pwd; m_pc = p_pc;
            foreach (mq[i]) if (mq[i].a3 == pa3) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = h.live;
            if (h.live) begin
                m_a3 = h.a3; m_wd = h.wd; m_pc = h.pc;
            end
        end else begin
            m_we = 1'b0;
        end
        if (push && (la3 != 5'd0)) begin
            h.a3 = la3; h.wd = lwd; h.pc = l_pc; h.live = 1'b1;
            mq.push_back(h);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        bit got;
        cmp = 0; bad = 0; cyc = 0;
        model_reset();
        clr_n = 1'b0;
        p_valid = 0; p_a3 = 0; p_wd = 0; p_pc = 0;
        l_valid = 0; l_a3 = 0; l_wd = 0; l_pc = 0;
        #1;
        chk("rst_l_ready", 64'(l_ready), 64'd0);
        chk("rst_grf", 64'({grf_we, grf_a3}), 64'd0);
        chk("rst_grf_wd", 64'(grf_wd), 64'd0);
        chk("rst_grf_pc", 64'(grf_pc), 64'd0);
        chk("rst_misc", 64'({pend, fifo_cnt, stall_req, proto_err}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_l_ready", 64'(l_ready), 64'd1);

        // Pipeline path, latency 1
        step(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        chk("pipe_we", 64'(grf_we), 64'd1);
        chk("pipe_a3", 64'(grf_a3), 64'd5);
        chk("pipe_wd", 64'(grf_wd), 64'hDEAD_BEEF);
        idle(1);

        // Long path alone
        step(0, 5'd0, 32'd0, 1, 5'd9, 32'h1234);
        chk("long_pend9", 64'(pend[9]), 64'd1);
        idle(1);
        chk("long_we", 64'(grf_we), 64'd1);
        chk("long_a3", 64'(grf_a3), 64'd9);
        chk("long_wd", 64'(grf_wd), 64'h1234);
        chk("long_pend9_clr", 64'(pend[9]), 64'd0);
        idle(1);

        // Squash by newer pipeline writes
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'h1);
        step(1, 5'd7, 32'h2, 0, 5'd0, 32'd0);
        chk("sq_pend7", 64'(pend[7]), 64'd0);
        chk("sq_cnt", 64'(fifo_cnt), 64'd1);
        step(1, 5'd7, 32'h2, 0, 5'd0, 32'd0);
        step(1, 5'd7, 32'h2, 0, 5'd0, 32'd0);
        idle(1);
        chk("sq_pop_we", 64'(grf_we), 64'd0);
        chk("sq_pop_cnt", 64'(fifo_cnt), 64'd0);
        idle(2);

        // Fill under continuous pipeline writes, then hold a 5th request
        for (int i = 0; i < 4; i++) step(1, 5'd3, 32'h300 + 32'(i), 1, 5'(10 + i), 32'hA0 + 32'(i));
        chk("full_cnt", 64'(fifo_cnt), 64'd4);
        chk("full_ready", 64'(l_ready), 64'd0);
        step(1, 5'd3, 32'h304, 1, 5'd14, 32'hA4);
        chk("full_noacc", 64'(acc), 64'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, 5'd0, 32'd0, 1, 5'd14, 32'hA4);
            got = acc;
        end
        chk("push5_accept", 64'(got), 64'd1);
        idle(6);
        chk("full_drained", 64'(fifo_cnt), 64'd0);

        // Starvation: stall after MAXWAIT waiting cycles, released by a bubble
        step(1, 5'd3, 32'h33, 1, 5'd20, 32'h2020);
        for (int i = 0; i < int'(MAXWAIT); i++) step(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
        chk("stall_set", 64'(stall_req), 64'd1);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("stall_issue_a3", 64'(grf_a3), 64'd20);
        chk("stall_clr", 64'(stall_req), 64'd0);
        chk("no_proto", 64'(proto_err), 64'd0);

        // Same again but the pipeline ignores the stall
        step(1, 5'd3, 32'h44, 1, 5'd21, 32'h2121);
        for (int i = 0; i < int'(MAXWAIT); i++) step(1, 5'd3, 32'h44, 0, 5'd0, 32'd0);
        step(1, 5'd4, 32'h45, 0, 5'd0, 32'd0);
        chk("proto_set", 64'(proto_err), 64'd1);
        chk("proto_pipe_a3", 64'(grf_a3), 64'd4);
        idle(4);
        chk("proto_sticky", 64'(proto_err), 64'd1);

        // a3 == 0 requests complete the handshake but are dropped
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF);
        chk("zero_acc", 64'(acc), 64'd1);
        chk("zero_cnt", 64'(fifo_cnt), 64'd0);
        idle(2);

        // Async reset with entries queued
        for (int i = 0; i < 3; i++) step(1, 5'd3, 32'h55, 1, 5'(24 + i), 32'hB0 + 32'(i));
        @(negedge clk);
        p_valid = 0; l_valid = 0;
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(fifo_cnt), 64'd0);
        chk("arst_pend", 64'(pend), 64'd0);
        chk("arst_ready", 64'(l_ready), 64'd0);
        chk("arst_proto", 64'(proto_err), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        idle(5);

        // Random traffic, narrow register range to provoke squashes
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 ($urandom % 2) != 0, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
